pitch_synth: RTL

- Tone generator: converts a 16.16 fixed-point frequency in Hz (same format as the pitch detector's frequency output) into a stream of signed audio samples at SAMPLE_RATE.
- Sits on the playback side of the audio path: the detected pitch, or any pitch command, drives it, and its samples feed the audio output/DAC path.
- Phase-accumulator (DDS) core, selectable waveform, phase-continuous frequency updates.

---
 rtl/pitch_synth_pkg.sv | 32 +++
 rtl/pitch_synth_sine_lut.sv | 21 ++
 rtl/pitch_synth.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pitch_synth_pkg.sv
// pitch_synth shared types and helpers.
// State encoding, waveform selector values and the DDS scale constant.
package pitch_synth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        WAVE_SQUARE = 2'd0,
        WAVE_SAW    = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SINE   = 2'd3
    } wave_t;

    localparam logic [8:0] SQ_POS   = 9'h0FF;
    localparam logic [8:0] SQ_NEG   = 9'h101;
    localparam logic [8:0] SIGN_FLP = 9'h100;

    // K = round(2^(phase_w+16) / sample_rate): Hz(16.16) -> phase step
    function automatic logic [63:0] calc_k(
        input int phase_w,
        input int sample_rate
    );
        logic [63:0] num;
        num = 64'd1 << (phase_w + 16);
        return (num + 64'(sample_rate / 2)) / 64'(sample_rate);
    endfunction

endpackage

// File: rtl/pitch_synth_sine_lut.sv
// Quarter-wave sine magnitude ROM.
// Entry i = round(255*sin((i+0.5)*pi/128)), mirrored by the caller.
module sine_quarter_lut (
    input  logic [5:0] i_idx,
    output logic [7:0] o_mag
);

    localparam logic [7:0] LUT [64] = '{
        8'd3,   8'd9,   8'd16,  8'd22,  8'd28,  8'd34,  8'd41,  8'd47,
        8'd53,  8'd59,  8'd65,  8'd71,  8'd77,  8'd83,  8'd89,  8'd95,
        8'd100, 8'd106, 8'd112, 8'd117, 8'd123, 8'd128, 8'd134, 8'd139,
        8'd144, 8'd149, 8'd154, 8'd159, 8'd164, 8'd169, 8'd174, 8'd178,
        8'd183, 8'd187, 8'd191, 8'd195, 8'd199, 8'd203, 8'd207, 8'd210,
        8'd214, 8'd217, 8'd220, 8'd223, 8'd226, 8'd229, 8'd232, 8'd234,
        8'd237, 8'd239, 8'd241, 8'd243, 8'd245, 8'd247, 8'd248, 8'd249,
        8'd251, 8'd252, 8'd253, 8'd253, 8'd254, 8'd255, 8'd255, 8'd255
    };

    assign o_mag = LUT[i_idx];

endmodule

// File: rtl/pitch_synth.sv
// DDS tone generator: 16.16 Hz in, signed samples out at SAMPLE_RATE.
// Frequency updates are phase-continuous; zero or >= Nyquist stops the tone.
module pitch_synth
    import pitch_synth_pkg::*;
#(
    parameter int SIG_WIDTH   = 9,
    parameter int WIDTH       = 32,
    parameter int PHASE_W     = 24,
    parameter int SAMPLE_RATE = 8000,
    parameter int CLK_HZ      = 100_000_000
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [WIDTH-1:0]     f_in,
    input  logic                 f_in_valid,
    output logic                 f_in_ready,
    input  logic [1:0]           wave_sel,
    output logic [SIG_WIDTH-1:0] sample_out,
    output logic                 sample_valid,
    output logic                 active,
    output logic                 f_err
);

    localparam int CLK_DIV = CLK_HZ / SAMPLE_RATE;
    localparam int CNT_W   = $clog2(CLK_DIV);

    localparam logic [63:0] K_FULL = calc_k(PHASE_W, SAMPLE_RATE);
    localparam int          K_W    = $clog2(K_FULL + 64'd1);
    localparam int          PROD_W = WIDTH + K_W;

    localparam logic [K_W-1:0]    K   = K_FULL[K_W-1:0];
    localparam logic [WIDTH-1:0]  NYQ = WIDTH'(SAMPLE_RATE / 2) << 16;
    localparam logic [PROD_W-1:0] RND = PROD_W'(1) << 31;

    state_t               r_state;
    logic                 r_step;
    logic [WIDTH-1:0]     r_f;
    logic [PROD_W-1:0]    r_prod;
    logic [PHASE_W-1:0]   r_inc;
    logic [PHASE_W-1:0]   r_phase;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_ready;
    logic                 r_active;
    logic                 r_f_err;
    logic                 r_sample_valid;
    logic [SIG_WIDTH-1:0] r_sample_out;

    logic                 w_accept;
    logic                 w_tick;
    logic                 w_commit;
    logic                 w_zero;
    logic                 w_nyq;
    logic                 w_stop;
    logic                 w_phase_clr;
    logic [PROD_W-1:0]    w_mult;
    logic [PROD_W-1:0]    w_round;
    logic [PHASE_W-1:0]   w_new_inc;
    logic                 w_unused;

    logic [1:0]           w_quad;
    logic [5:0]           w_idx;
    logic [5:0]           w_lut_idx;
    logic [7:0]           w_mag;
    logic [8:0]           w_mag9;
    logic [8:0]           w_p9;
    logic [8:0]           w_tri;
    logic [8:0]           w_wave;

    assign w_accept  = f_in_valid && r_ready;
    assign w_tick    = (r_cnt == CNT_W'(CLK_DIV - 1));
    assign w_commit  = (r_state == ST_LOAD) && r_step;
    assign w_zero    = (r_f == '0);
    assign w_nyq     = (r_f >= NYQ);
    assign w_stop    = w_zero || w_nyq;
    assign w_phase_clr = w_commit && w_stop;

    assign w_mult    = {{(PROD_W - WIDTH){1'b0}}, r_f}
                     * {{(PROD_W - K_W){1'b0}}, K};
    assign w_round   = r_prod + RND;
    assign w_new_inc = w_round[32 +: PHASE_W];
    assign w_unused  = ^{w_round[31:0],
                         w_round[PROD_W-1:32+PHASE_W]};

    // Control FSM: latch request, two-cycle increment calc, commit
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state  <= ST_IDLE;
            r_step   <= 1'b0;
            r_f      <= '0;
            r_prod   <= '0;
            r_inc    <= '0;
            r_ready  <= 1'b1;
            r_active <= 1'b0;
            r_f_err  <= 1'b0;
        end else begin
            r_f_err <= 1'b0;
            unique case (r_state)
                ST_IDLE, ST_RUN: begin
                    if (w_accept) begin
                        r_f     <= f_in;
                        r_ready <= 1'b0;
                        r_step  <= 1'b0;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!r_step) begin
                        r_prod <= w_mult;
                        r_step <= 1'b1;
                    end else begin
                        r_step  <= 1'b0;
                        r_ready <= 1'b1;
                        if (w_stop) begin
                            r_inc    <= '0;
                            r_active <= 1'b0;
                            r_f_err  <= w_nyq;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_inc    <= w_new_inc;
                            r_active <= 1'b1;
                            r_state  <= ST_RUN;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Free-running sample tick divider, independent of state
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_p9      = r_phase[PHASE_W-1 -: 9];
    assign w_quad    = r_phase[PHASE_W-1 -: 2];
    assign w_idx     = r_phase[PHASE_W-3 -: 6];
    assign w_lut_idx = w_quad[0] ? ~w_idx : w_idx;
    assign w_tri     = r_phase[PHASE_W-2 -: 9];
    assign w_mag9    = {1'b0, w_mag};

    sine_quarter_lut u_lut (
        .i_idx (w_lut_idx),
        .o_mag (w_mag)
    );

    // Waveform shaping from the current phase
    always_comb begin
        w_wave = '0;
        unique case (wave_t'(wave_sel))
            WAVE_SQUARE: begin
                w_wave = r_phase[PHASE_W-1] ? SQ_NEG : SQ_POS;
            end
            WAVE_SAW: begin
                w_wave = w_p9 ^ SIGN_FLP;
            end
            WAVE_TRI: begin
                w_wave = r_phase[PHASE_W-1] ? (~w_tri) ^ SIGN_FLP
                                            : w_tri ^ SIGN_FLP;
            end
            WAVE_SINE: begin
                w_wave = w_quad[1] ? (~w_mag9) + 9'd1 : w_mag9;
            end
            default: begin
                w_wave = '0;
            end
        endcase
    end

    // Sample emission and phase advance on each tick
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_phase        <= '0;
            r_sample_valid <= 1'b0;
            r_sample_out   <= '0;
        end else begin
            r_sample_valid <= w_tick;
            if (w_tick) begin
                r_sample_out <= r_active
                              ? SIG_WIDTH'($signed(w_wave))
                              : '0;
            end
            if (w_phase_clr) begin
                r_phase <= '0;
            end else if (w_tick) begin
                r_phase <= r_phase + r_inc;
            end
        end
    end

    assign f_in_ready   = r_ready;
    assign sample_out   = r_sample_out;
    assign sample_valid = r_sample_valid;
    assign active       = r_active;
    assign f_err        = r_f_err;

endmodule
